// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types for the CPU clock run/step/halt controller.
package cpu_clk_ctrl_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } ctrl_state_t;

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// Control/status bundle between the board (buttons, CPU, config) and the clock controller.
interface cpu_clk_ctrl_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 32
);
  import cpu_clk_ctrl_pkg::*;

  logic             run_btn;
  logic             stop_btn;
  logic             step_btn;
  logic             halt_req;
  logic             cfg_we;
  logic [DIV_W-1:0] cfg_div;
  logic             cpu_ce;
  ctrl_state_t      state;
  logic             halted;
  logic [CNT_W-1:0] ce_count;

  // Board side: raw buttons, CPU halt request and divider configuration.
  modport master (
    output run_btn, stop_btn, step_btn, halt_req, cfg_we, cfg_div,
    input  cpu_ce, state, halted, ce_count
  );

  // Controller side.
  modport slave (
    input  run_btn, stop_btn, step_btn, halt_req, cfg_we, cfg_div,
    output cpu_ce, state, halted, ce_count
  );

endinterface

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability filter and rising-edge pulse.
module btn_debounce #(
  parameter int DB_CYC = 50000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = (DB_CYC < 2) ? 1 : $clog2(DB_CYC + 1);

  logic          sync0;
  logic          sync1;
  logic [CW-1:0] stable_cnt;

  // Bring the raw asynchronous button into the clock domain.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= btn_raw;
      sync1 <= sync0;
    end
  end

  // Accept a new level only after DB_CYC consecutive samples disagree with the current one;
  // any sample that agrees restarts the count, so short glitches are dropped.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      stable_cnt <= '0;
    end else begin
      rise_pulse <= 1'b0;
      if (sync1 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DB_CYC - 1)) begin
        level      <= sync1;
        rise_pulse <= sync1;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: RUN at a programmable divide ratio, single STEP, or HALT.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 1,
  parameter int DB_CYC      = 50000,
  parameter int CNT_W       = 32
) (
  input logic           clk_in,
  input logic           rst,
  cpu_clk_ctrl_if.slave bus
);

  ctrl_state_t      state_q;
  logic             cpu_ce_q;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] ce_count_q;
  logic             run_pulse;
  logic             stop_pulse;
  logic             step_pulse;
  logic [2:0]       unused_levels;

  btn_debounce #(.DB_CYC(DB_CYC)) u_run_db (
    .clk_in     (clk_in),
    .rst        (rst),
    .btn_raw    (bus.run_btn),
    .level      (unused_levels[0]),
    .rise_pulse (run_pulse)
  );

  btn_debounce #(.DB_CYC(DB_CYC)) u_stop_db (
    .clk_in     (clk_in),
    .rst        (rst),
    .btn_raw    (bus.stop_btn),
    .level      (unused_levels[1]),
    .rise_pulse (stop_pulse)
  );

  btn_debounce #(.DB_CYC(DB_CYC)) u_step_db (
    .clk_in     (clk_in),
    .rst        (rst),
    .btn_raw    (bus.step_btn),
    .level      (unused_levels[2]),
    .rise_pulse (step_pulse)
  );

  // Mode FSM, divider and enable counter; cpu_ce is registered alongside the state
  // it belongs to, and a config write restarts the divide period without a pulse.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HALT;
      cpu_ce_q   <= 1'b0;
      div_reg    <= DIV_W'(DIV_DEFAULT);
      div_cnt    <= '0;
      ce_count_q <= '0;
    end else begin
      cpu_ce_q <= 1'b0;
      if (bus.cfg_we) begin
        div_reg <= bus.cfg_div;
        div_cnt <= '0;
      end
      case (state_q)
        ST_HALT: begin
          div_cnt <= '0;
          if (stop_pulse) begin
            state_q <= ST_HALT;
          end else if (run_pulse) begin
            state_q <= ST_RUN;
          end else if (step_pulse) begin
            state_q    <= ST_STEP;
            cpu_ce_q   <= 1'b1;
            ce_count_q <= ce_count_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.halt_req || stop_pulse) begin
            state_q <= ST_HALT;
            div_cnt <= '0;
          end else if (!bus.cfg_we) begin
            if (div_cnt == div_reg) begin
              cpu_ce_q   <= 1'b1;
              ce_count_q <= ce_count_q + 1'b1;
              div_cnt    <= '0;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
        ST_STEP: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  assign bus.cpu_ce   = cpu_ce_q;
  assign bus.state    = state_q;
  assign bus.halted   = (state_q == ST_HALT);
  assign bus.ce_count = ce_count_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Randomized scoreboard bench for cpu_clk_ctrl with an event-time reference model.
module tb_cpu_clk_ctrl;

  localparam int DB      = 4;
  localparam int DW      = 16;
  localparam int CW      = 4;
  localparam int DIV_DEF = 1;

  typedef struct {
    int edge_at;
    int count;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  int   vectors     = 0;
  int   miscompares = 0;
  int   edge_no     = 0;

  int   m_state;
  int   m_div;
  int   m_next_fire;
  int   m_count;
  int   run_eff;
  int   stop_eff;
  int   step_eff;
  exp_t exp_q[$];
  exp_t mon_e;

  cpu_clk_ctrl_if #(.DIV_W(DW), .CNT_W(CW)) bus ();

  cpu_clk_ctrl #(
    .DIV_W       (DW),
    .DIV_DEFAULT (DIV_DEF),
    .DB_CYC      (DB),
    .CNT_W       (CW)
  ) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus)
  );

  // Free-running board clock.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_no);
    end
  endtask

  function automatic void model_reset();
    m_state     = 0;
    m_div       = DIV_DEF;
    m_next_fire = -1;
    m_count     = 0;
    run_eff     = -1;
    stop_eff    = -1;
    step_eff    = -1;
    exp_q.delete();
  endfunction

  // Reference model in absolute edge times: each RUN pulse is scheduled
  // div+1 edges after RUN entry, the previous pulse, or a config write.
  function automatic void model_edge(input int n, input bit hr, input bit cw, input int cd);
    bit rp      = (run_eff == n);
    bit sp      = (stop_eff == n);
    bit tp      = (step_eff == n);
    bit ce      = 1'b0;
    int new_div = cw ? cd : m_div;
    case (m_state)
      0: begin
        if (sp) begin
          m_state = 0;
        end else if (rp) begin
          m_state     = 1;
          m_next_fire = n + new_div + 1;
        end else if (tp) begin
          m_state = 2;
          ce      = 1'b1;
        end
      end
      1: begin
        if (hr || sp) begin
          m_state = 0;
        end else if (cw) begin
          m_next_fire = n + new_div + 1;
        end else if (n == m_next_fire) begin
          ce          = 1'b1;
          m_next_fire = n + m_div + 1;
        end
      end
      default: m_state = 0;
    endcase
    m_div = new_div;
    if (ce) begin
      m_count = (m_count + 1) % (1 << CW);
      exp_q.push_back('{n, m_count});
    end
  endfunction

  // Advance whole clock cycles, stepping the model and checking state each cycle.
  task automatic apply_stimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      edge_no++;
      model_edge(edge_no, bus.halt_req, bus.cfg_we, int'(bus.cfg_div));
      #1;
      check_output("state", bus.state, m_state);
      check_output("halted", bus.halted, m_state == 0);
    end
  endtask

  // Press buttons together for 'hold' cycles, then release and let the filter settle.
  task automatic press(input bit r, input bit s, input bit t, input int hold);
    int t0 = edge_no;
    if (hold >= DB) begin
      if (r) run_eff  = t0 + 3 + DB;
      if (s) stop_eff = t0 + 3 + DB;
      if (t) step_eff = t0 + 3 + DB;
    end
    bus.run_btn  = r;
    bus.stop_btn = s;
    bus.step_btn = t;
    apply_stimulus(hold);
    bus.run_btn  = 1'b0;
    bus.stop_btn = 1'b0;
    bus.step_btn = 1'b0;
    apply_stimulus(DB + 10);
  endtask

  task automatic pulse_halt();
    bus.halt_req = 1'b1;
    apply_stimulus(1);
    bus.halt_req = 1'b0;
  endtask

  task automatic write_div(input int d);
    bus.cfg_we  = 1'b1;
    bus.cfg_div = DW'(d);
    apply_stimulus(1);
    bus.cfg_we  = 1'b0;
  endtask

  // Scoreboard monitor: every cpu_ce pulse must match the next expected pulse.
  always @(negedge clk) begin
    if (!rst && bus.cpu_ce) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_pulse: got cpu_ce=1 ce_count=%0d, expected no pulse (edge %0d)",
                 bus.ce_count, edge_no);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("pulse_edge", edge_no, mon_e.edge_at);
        check_output("ce_count", bus.ce_count, mon_e.count);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.run_btn  = 1'b0;
    bus.stop_btn = 1'b0;
    bus.step_btn = 1'b0;
    bus.halt_req = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_div  = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_state", bus.state, 0);
    check_output("rst_cpu_ce", bus.cpu_ce, 0);
    check_output("rst_ce_count", bus.ce_count, 0);
    check_output("rst_halted", bus.halted, 1);
    rst = 1'b0;

    // RUN at default divide: pulse every 2nd cycle.
    press(1'b1, 1'b0, 1'b0, 10);
    apply_stimulus(10);

    // Divide 0 then divide 3.
    write_div(0);
    apply_stimulus(6);
    write_div(3);
    apply_stimulus(12);

    // halt_req landing on the cycle a pulse would fire.
    for (int k = 0; k < 20 && m_next_fire != edge_no + 1; k++) apply_stimulus(1);
    pulse_halt();
    apply_stimulus(4);

    // Single step, then a too-short step glitch.
    press(1'b0, 1'b0, 1'b1, 6);
    press(1'b0, 1'b0, 1'b1, 2);
    press(1'b0, 1'b0, 1'b1, DB);

    // run+stop together from HALT, then from RUN.
    press(1'b1, 1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 1'b0, 8);
    press(1'b1, 1'b1, 1'b0, 8);

    // Counter wrap with divide 0.
    write_div(0);
    press(1'b1, 1'b0, 1'b0, 6);
    apply_stimulus(24);

    // Asynchronous reset in the middle of a RUN cycle.
    #3;
    check_output("pre_reset_ce", bus.cpu_ce, 1);
    rst = 1'b1;
    #1;
    check_output("async_rst_cpu_ce", bus.cpu_ce, 0);
    check_output("async_rst_state", bus.state, 0);
    check_output("async_rst_ce_count", bus.ce_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus(3);

    // Randomized mix of operations.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 6))
        0: press(1'b1, 1'b0, 1'b0, $urandom_range(1, 8));
        1: press(1'b0, 1'b1, 1'b0, $urandom_range(1, 8));
        2: press(1'b0, 1'b0, 1'b1, $urandom_range(1, 8));
        3: pulse_halt();
        4: write_div($urandom_range(0, 3));
        5: press(1'b1, 1'b1, 1'b0, $urandom_range(1, 8));
        default: apply_stimulus($urandom_range(1, 6));
      endcase
    end
    apply_stimulus(10);
    check_output("pending_pulses", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
